uart_tx_arb: RTL and testbench

UART_TX_ARB -- requirements
Module: uart_tx_arb

---
 rtl/uart_tx_arb_if.sv | 25 ++
 rtl/uart_tx_arb.sv | 146 ++++++++++++++
 tb/tb_uart_tx_arb.sv | 309 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_arb_if.sv
// Byte-stream bundle between N_PORTS requesters, the arbiter and the UART transmitter.
// master: the side that owns the requesting streams and the UART ready.
// slave:  the arbiter itself.
interface uart_tx_arb_if #(
    parameter int N_PORTS    = 4,
    parameter int DATA_WIDTH = 8
);
    logic [N_PORTS*DATA_WIDTH-1:0] s_axis_tdata;
    logic [N_PORTS-1:0]            s_axis_tvalid;
    logic [N_PORTS-1:0]            s_axis_tlast;
    logic [N_PORTS-1:0]            s_axis_tready;
    logic [DATA_WIDTH-1:0]         m_axis_tdata;
    logic                          m_axis_tvalid;
    logic                          m_axis_tready;

    modport master (
        output s_axis_tdata, s_axis_tvalid, s_axis_tlast, m_axis_tready,
        input  s_axis_tready, m_axis_tdata, m_axis_tvalid
    );

    modport slave (
        input  s_axis_tdata, s_axis_tvalid, s_axis_tlast, m_axis_tready,
        output s_axis_tready, m_axis_tdata, m_axis_tvalid
    );
endinterface

// File: rtl/uart_tx_arb.sv
// Round-robin message arbiter feeding one UART transmitter.
// A port is granted for a whole message (until its tlast beat); ports are
// searched upward from the port after the last grant.
// Optional feature: define UART_TX_ARB_TIMEOUT_EN to force a lock release
// after TIMEOUT consecutive locked cycles without a transfer.
//
// state     | meaning
// ----------+---------------------------------------------------
// ST_IDLE   | no lock, pick the next requester this cycle
// ST_LOCKED | grant_id owns the output until tlast (or timeout)
module uart_tx_arb #(
    parameter int N_PORTS    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int TIMEOUT    = 1024,
    localparam int GW        = $clog2(N_PORTS)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    uart_tx_arb_if.slave          bus,
    output logic [GW-1:0]         grant_id,
    output logic                  grant_active,
    output logic                  timeout
);

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    state_t                r_state;
    logic [GW-1:0]         r_grant_id;
    logic [DATA_WIDTH-1:0] r_m_tdata;
    logic                  r_m_tvalid;
    logic                  r_timeout;

    logic                  w_out_free;
    logic                  w_xfer;
    logic                  w_last;
    logic                  w_req_any;
    logic                  w_to_hit;
    logic [GW:0]           w_sum;
    logic [GW-1:0]         w_next_id;
    logic [DATA_WIDTH-1:0] w_sel_data;
    logic [N_PORTS-1:0]    w_s_tready;

    // The output register can take a byte when empty or being drained this cycle.
    assign w_out_free = !r_m_tvalid || bus.m_axis_tready;
    assign w_last     = bus.s_axis_tlast[r_grant_id];
    assign w_sel_data = bus.s_axis_tdata[int'(r_grant_id)*DATA_WIDTH +: DATA_WIDTH];
    assign w_xfer     = (r_state == ST_LOCKED) && bus.s_axis_tvalid[r_grant_id] && w_out_free;

    // Round-robin search: walk offsets from far to near so the nearest requester wins.
    // r_grant_id doubles as last_grant since it is only updated on a new grant.
    always_comb begin
        w_req_any = 1'b0;
        w_next_id = r_grant_id;
        w_sum     = '0;
        for (int i = N_PORTS; i >= 1; i--) begin
            w_sum = {1'b0, r_grant_id} + (GW+1)'(i);
            if (w_sum >= (GW+1)'(N_PORTS)) begin
                w_sum = w_sum - (GW+1)'(N_PORTS);
            end
            if (bus.s_axis_tvalid[w_sum[GW-1:0]]) begin
                w_req_any = 1'b1;
                w_next_id = w_sum[GW-1:0];
            end
        end
    end

    // Only the granted port sees ready, and only while locked.
    always_comb begin
        w_s_tready = '0;
        if (r_state == ST_LOCKED) begin
            w_s_tready[r_grant_id] = w_out_free;
        end
    end

`ifdef UART_TX_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] r_idle_cnt;

    assign w_to_hit = (r_state == ST_LOCKED) && !w_xfer && (r_idle_cnt == CW'(TIMEOUT - 1));

    // Count locked cycles without a transfer; held at zero while idle so each lock starts fresh.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idle_cnt <= '0;
        end else if (r_state == ST_IDLE || w_xfer || w_to_hit) begin
            r_idle_cnt <= '0;
        end else begin
            r_idle_cnt <= r_idle_cnt + 1'b1;
        end
    end
`else
    // Without the timeout option the threshold has no hardware behind it.
    logic w_unused_timeout;
    assign w_unused_timeout = (TIMEOUT > 0);
    assign w_to_hit         = 1'b0;
`endif

    // Lock state machine plus the one-deep output register toward the UART.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_grant_id <= GW'(N_PORTS - 1);
            r_m_tdata  <= '0;
            r_m_tvalid <= 1'b0;
            r_timeout  <= 1'b0;
        end else begin
            r_timeout <= 1'b0;
            if (w_xfer) begin
                r_m_tdata  <= w_sel_data;
                r_m_tvalid <= 1'b1;
            end else if (bus.m_axis_tready) begin
                r_m_tvalid <= 1'b0;
            end
            case (r_state)
                ST_IDLE: begin
                    if (w_req_any) begin
                        r_state    <= ST_LOCKED;
                        r_grant_id <= w_next_id;
                    end
                end
                ST_LOCKED: begin
                    // A pending output byte keeps draining after release.
                    if (w_xfer && w_last) begin
                        r_state <= ST_IDLE;
                    end else if (w_to_hit) begin
                        r_state   <= ST_IDLE;
                        r_timeout <= 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.s_axis_tready = w_s_tready;
    assign bus.m_axis_tdata  = r_m_tdata;
    assign bus.m_axis_tvalid = r_m_tvalid;
    assign grant_id          = r_grant_id;
    assign grant_active      = (r_state == ST_LOCKED);
    assign timeout           = r_timeout;

endmodule

// File: tb/tb_uart_tx_arb.sv
// Bench for uart_tx_arb: directed scenarios plus randomized traffic checked
// against a message-level round-robin model.
module tb_uart_tx_arb;
    localparam int N  = 4;
    localparam int DW = 8;
    localparam int TO = 16;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] grant_id;
    logic       grant_active;
    logic       timeout;

    uart_tx_arb_if #(.N_PORTS(N), .DATA_WIDTH(DW)) bus ();

    uart_tx_arb #(.N_PORTS(N), .DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .bus          (bus),
        .grant_id     (grant_id),
        .grant_active (grant_active),
        .timeout      (timeout)
    );

    always #5 clk = ~clk;

    int         n_cmp = 0;
    int         n_bad = 0;
    logic [8:0] src_q [N][$];   // {tlast, data} per port
    logic [8:0] exp_q [$];
    int         out_cyc [$];
    int         mdl_last;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_port(input int p, input logic v, input logic [7:0] d, input logic l);
        bus.s_axis_tvalid[p]         = v;
        bus.s_axis_tdata[p*DW +: DW] = d;
        bus.s_axis_tlast[p]          = l;
    endtask

    task automatic drive_idle();
        bus.s_axis_tvalid = '0;
        bus.s_axis_tdata  = '0;
        bus.s_axis_tlast  = '0;
        bus.m_axis_tready = 1'b0;
    endtask

    task automatic push_msg(input int p, input logic [7:0] first, input int len);
        for (int b = 0; b < len; b++) src_q[p].push_back({b == len - 1, 8'(first + b)});
    endtask

    task automatic do_reset();
        drive_idle();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        mdl_last = N - 1;
        for (int p = 0; p < N; p++) src_q[p].delete();
        exp_q.delete();
    endtask

    // Whole messages in round-robin order among ports that have something queued.
    task automatic model_build();
        logic [8:0] q [N][$];
        logic [8:0] b;
        int         p;
        bit         found;
        for (int i = 0; i < N; i++) q[i] = src_q[i];
        exp_q.delete();
        forever begin
            found = 1'b0;
            p     = 0;
            for (int k = 1; k <= N; k++) begin
                p = (mdl_last + k) % N;
                if (q[p].size() > 0) begin
                    found = 1'b1;
                    break;
                end
            end
            if (!found) break;
            do begin
                b = q[p].pop_front();
                exp_q.push_back(b);
            end while (!b[8] && q[p].size() > 0);
            mdl_last = p;
        end
    endtask

    // mode 0: ready always high; 1: random ready and mid-message source gaps;
    // 2: ready low for 5 cycles starting at cycle win_lo.
    task automatic run_traffic(input int max_cyc, input int mode, input int win_lo);
        int         cyc;
        int         tot;
        logic [N-1:0] xin;
        logic [7:0] hold;
        bit         held;
        bit         mid [N];
        logic [8:0] e;
        cyc  = 0;
        held = 1'b0;
        hold = '0;
        for (int p = 0; p < N; p++) mid[p] = 1'b0;
        out_cyc.delete();
        model_build();
        @(negedge clk);
        while (cyc < max_cyc) begin
            for (int p = 0; p < N; p++) begin
                if (src_q[p].size() > 0 && !(mode == 1 && mid[p] && $urandom_range(0, 2) == 0))
                    set_port(p, 1'b1, src_q[p][0][7:0], src_q[p][0][8]);
                else
                    set_port(p, 1'b0, 8'h00, 1'b0);
            end
            if (mode == 1)
                bus.m_axis_tready = ($urandom_range(0, 3) != 0);
            else if (mode == 2 && cyc >= win_lo && cyc < win_lo + 5)
                bus.m_axis_tready = 1'b0;
            else
                bus.m_axis_tready = 1'b1;
            #1;
            chk("tready_onehot0", 32'($onehot0(bus.s_axis_tready)), 32'd1);
            xin = bus.s_axis_tvalid & bus.s_axis_tready;
            if (bus.m_axis_tvalid && bus.m_axis_tready) begin
                e = 'x;
                if (exp_q.size() > 0) e = exp_q.pop_front();
                chk("out_data", 32'(bus.m_axis_tdata), 32'(e[7:0]));
                out_cyc.push_back(cyc);
            end
            if (mode == 2 && bus.m_axis_tvalid && !bus.m_axis_tready) begin
                chk("bp_s_tready", 32'(bus.s_axis_tready), 32'd0);
                if (!held) begin
                    hold = bus.m_axis_tdata;
                    held = 1'b1;
                end else begin
                    chk("bp_hold", 32'(bus.m_axis_tdata), 32'(hold));
                end
            end
            tot = 0;
            for (int p = 0; p < N; p++) tot += src_q[p].size();
            if (tot == 0 && exp_q.size() == 0 && !bus.m_axis_tvalid) break;
            @(posedge clk);
            for (int p = 0; p < N; p++) begin
                if (xin[p]) begin
                    mid[p] = !src_q[p][0][8];
                    void'(src_q[p].pop_front());
                end
            end
            @(negedge clk);
            cyc++;
        end
        chk("traffic_done_in_budget", 32'(cyc < max_cyc), 32'd1);
        drive_idle();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int  to_at;
        bit  seen;
        logic [7:0] d;

        // Reset values
        rst_n = 1'b0;
        drive_idle();
        for (int p = 0; p < N; p++) src_q[p].delete();
        mdl_last = N - 1;
        repeat (2) @(negedge clk);
        chk("rst_s_tready", 32'(bus.s_axis_tready), 32'd0);
        chk("rst_m_tvalid", 32'(bus.m_axis_tvalid), 32'd0);
        chk("rst_m_tdata", 32'(bus.m_axis_tdata), 32'd0);
        chk("rst_grant_id", 32'(grant_id), 32'd3);
        chk("rst_grant_active", 32'(grant_active), 32'd0);
        chk("rst_timeout", 32'(timeout), 32'd0);
        rst_n = 1'b1;

        // Contention: ports 0,1,3 with 2-byte messages -> 0,1,3 order
        push_msg(0, 8'h01, 2);
        push_msg(1, 8'h11, 2);
        push_msg(3, 8'h31, 2);
        run_traffic(200, 0, 0);
        chk("b_last_grant", 32'(grant_id), 32'd3);

        // Single port 2: 41,42,43 on consecutive cycles
        push_msg(2, 8'h41, 3);
        run_traffic(200, 0, 0);
        chk("a_beats", 32'(out_cyc.size()), 32'd3);
        if (out_cyc.size() == 3) chk("a_consecutive", 32'(out_cyc[2] - out_cyc[0]), 32'd2);
        chk("a_grant_id", 32'(grant_id), 32'd2);
        chk("a_idle_after", 32'(grant_active), 32'd0);

        // Round-robin: port 0 has two messages, port 1 one -> 0, 1, 0
        push_msg(0, 8'h05, 2);
        push_msg(0, 8'h07, 1);
        push_msg(1, 8'h15, 1);
        run_traffic(200, 0, 0);
        chk("c_last_grant", 32'(grant_id), 32'd0);

        // Backpressure mid-message on port 1
        push_msg(1, 8'hA0, 6);
        run_traffic(200, 2, 4);
        chk("d_beats", 32'(out_cyc.size()), 32'd6);

        // Port 1 stalls mid-message while port 2 waits
        @(negedge clk);
        set_port(1, 1'b1, 8'h10, 1'b0);
        bus.m_axis_tready = 1'b1;
        @(posedge clk);
        #1;
        chk("e_grant_p1", 32'(grant_id), 32'd1);
        @(posedge clk);
        #1;
        chk("e_byte", 32'(bus.m_axis_tdata), 32'h10);
        @(negedge clk);
        set_port(1, 1'b0, 8'h00, 1'b0);
        set_port(2, 1'b1, 8'h20, 1'b1);
`ifdef UART_TX_ARB_TIMEOUT_EN
        to_at = 0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            #1;
            if (timeout) begin
                to_at = k;
                break;
            end
        end
        chk("e_timeout_at", 32'(to_at), 32'd16);
        @(posedge clk);
        #1;
        chk("e_timeout_pulse_one", 32'(timeout), 32'd0);
        chk("e_grant_p2", 32'(grant_id), 32'd2);
        chk("e_grant_active", 32'(grant_active), 32'd1);
`else
        seen = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            #1;
            if (timeout || bus.s_axis_tready[2]) seen = 1'b1;
        end
        chk("e_no_release", 32'(seen), 32'd0);
        chk("e_still_p1", 32'(grant_id), 32'd1);
        chk("e_still_locked", 32'(grant_active), 32'd1);
`endif
        do_reset();

        // Reset mid-message on port 3 after its 2nd byte
        @(negedge clk);
        set_port(3, 1'b1, 8'h31, 1'b0);
        bus.m_axis_tready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        @(posedge clk);
        @(negedge clk);
        set_port(3, 1'b1, 8'h32, 1'b0);
        @(posedge clk);
        @(negedge clk);
        #1;
        chk("f_pre_data", 32'(bus.m_axis_tdata), 32'h32);
        chk("f_pre_valid", 32'(bus.m_axis_tvalid), 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("f_async_m_tvalid", 32'(bus.m_axis_tvalid), 32'd0);
        chk("f_async_m_tdata", 32'(bus.m_axis_tdata), 32'd0);
        chk("f_async_s_tready", 32'(bus.s_axis_tready), 32'd0);
        chk("f_async_grant_id", 32'(grant_id), 32'd3);
        chk("f_async_active", 32'(grant_active), 32'd0);
        set_port(3, 1'b1, 8'h33, 1'b0);
        set_port(0, 1'b1, 8'h01, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("f_port0_wins", 32'(grant_id), 32'd0);
        chk("f_locked", 32'(grant_active), 32'd1);
        do_reset();

        // Randomized traffic against the message-level model
        for (int r = 0; r < 4; r++) begin
            for (int p = 0; p < N; p++) begin
                int nm;
                nm = $urandom_range(0, 3);
                for (int m = 0; m < nm; m++) begin
                    int len;
                    len = $urandom_range(1, 4);
                    for (int b = 0; b < len; b++) begin
                        d = 8'($urandom);
                        src_q[p].push_back({b == len - 1, d});
                    end
                end
            end
            run_traffic(3000, 1, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
